// File: rtl/ladybird_ram_responder_if.sv
// Ladybird req/gnt/data_gnt memory bus bundle.
// The initiator drives the request side; the responder drives grant, completion and read data.
interface ladybird_ram_responder_if #(
  parameter int unsigned XLEN = 32
);
  logic              req;
  logic              gnt;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic [XLEN/8-1:0] wstrb;
  logic [XLEN-1:0]   rdata;
  logic              data_gnt;

  modport master (
    output req, addr, wdata, wstrb,
    input  gnt, rdata, data_gnt
  );

  modport slave (
    input  req, addr, wdata, wstrb,
    output gnt, rdata, data_gnt
  );
endinterface

// File: rtl/ladybird_ram_responder.sv
// Single-ported word RAM responder on the ladybird bus.
// Serves one transaction at a time and pulses data_gnt LATENCY cycles after the grant.
module ladybird_ram_responder #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  ladybird_ram_responder_if.slave bus
);

  localparam int unsigned DEPTH  = 32'd1 << DEPTH_LOG2;
  localparam int          NBYTES = int'(XLEN / 32'd8);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 32'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  data_gnt_q, data_gnt_d;
  logic [XLEN-1:0]       rdata_q, rdata_d;
  logic                  gnt_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic                  unused_addr_s;
  logic [XLEN-1:0]       mem_q [DEPTH];

  // Byte offset and high bits are dropped: accesses are word-aligned and alias modulo the array size.
  assign idx_s         = bus.addr[DEPTH_LOG2+1:2];
  assign unused_addr_s = ^{bus.addr[XLEN-1:DEPTH_LOG2+2], bus.addr[1:0]};

  assign gnt_s   = bus.req & (state_q == IDLE) & ~rst;
  assign wr_en_s = gnt_s & (|bus.wstrb);
  assign rd_en_s = gnt_s & ~(|bus.wstrb);

  assign bus.gnt      = gnt_s;
  assign bus.rdata    = rdata_q;
  assign bus.data_gnt = data_gnt_q;

  // Next-state, latency counter and read-data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_s) begin
          cnt_d   = LAT_M1;
          state_d = (LATENCY > 32'd1) ? WAIT : RESP;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (rd_en_s) begin
      rdata_d = mem_q[idx_s];
    end else begin
      rdata_d = rdata_q;
    end
    data_gnt_d = (state_d == RESP);
  end

  // Control and response registers; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      data_gnt_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_gnt_q <= data_gnt_d;
      rdata_q    <= rdata_d;
    end
  end

  // Byte-lane write port; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (bus.wstrb[i]) begin
          mem_q[idx_s][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ladybird_ram_responder.sv
// Bench for ladybird_ram_responder: directed vector table, reset and back-to-back sequences,
// then randomized traffic checked against a word-array reference model.
module tb_ladybird_ram_responder;

  localparam int LAT = 2;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  ladybird_ram_responder_if #(.XLEN(32)) bus0 ();
  ladybird_ram_responder_if #(.XLEN(32)) bus1 ();

  ladybird_ram_responder #(.XLEN(32), .DEPTH_LOG2(12), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  ladybird_ram_responder #(.XLEN(32), .DEPTH_LOG2(12), .LATENCY(1)) dut_l1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: word array indexed by (byte address / 4) mod 4096.
  logic [31:0] mdl [4096];
  logic [31:0] last_rd;

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % 32'd4096);
  endfunction

  function automatic void mdl_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] w;
    w = mdl[widx(a)];
    for (int b = 0; b < 4; b++) begin
      if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
    end
    mdl[widx(a)] = w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction on bus0: waits for gnt, checks latency, pulse width and rdata.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input logic [31:0] exp_rd, input string nm);
    int  t_g;
    int  t_d;
    int  n;
    bit  got;
    bus0.req   = 1'b1;
    bus0.addr  = a;
    bus0.wdata = wd;
    bus0.wstrb = ws;
    got = 1'b0;
    n   = 0;
    t_g = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (bus0.gnt) begin
        got = 1'b1;
        t_g = cyc;
      end
      step();
      n++;
    end
    bus0.req   = 1'b0;
    bus0.wstrb = 4'h0;
    if (!got) begin
      chk({nm, "_gnt_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (ws != 4'h0) mdl_write(a, wd, ws);
    got = 1'b0;
    n   = 0;
    t_d = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (bus0.data_gnt) begin
        got = 1'b1;
        t_d = cyc;
      end else begin
        step();
        n++;
      end
    end
    if (!got) begin
      chk({nm, "_dgnt_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({nm, "_latency"}, 32'(t_d - t_g), 32'(LAT));
    chk({nm, "_rdata"}, bus0.rdata, exp_rd);
    step();
    @(negedge clk);
    chk({nm, "_dgnt_pulse"}, {31'd0, bus0.data_gnt}, 32'd0);
    step();
  endtask

  // Holds req high for three reads and checks grant spacing and gnt/data_gnt exclusion.
  task automatic b2b(input int which, input int lat);
    int grants[$];
    int n;
    logic g;
    logic dg;
    if (which == 1) begin
      bus1.req = 1'b1; bus1.addr = 32'h10; bus1.wstrb = 4'h0;
    end else begin
      bus0.req = 1'b1; bus0.addr = 32'h10; bus0.wstrb = 4'h0;
    end
    n = 0;
    while (grants.size() < 3 && n < 40) begin
      @(negedge clk);
      g  = (which == 1) ? bus1.gnt : bus0.gnt;
      dg = (which == 1) ? bus1.data_gnt : bus0.data_gnt;
      chk($sformatf("b2b%0d_overlap", which), {31'd0, g & dg}, 32'd0);
      if (g) grants.push_back(cyc);
      step();
      n++;
    end
    bus0.req = 1'b0;
    bus1.req = 1'b0;
    chk($sformatf("b2b%0d_ngrants", which), 32'(grants.size()), 32'd3);
    if (grants.size() == 3) begin
      chk($sformatf("b2b%0d_gap1", which), 32'(grants[1] - grants[0]), 32'(lat + 1));
      chk($sformatf("b2b%0d_gap2", which), 32'(grants[2] - grants[1]), 32'(lat + 1));
    end
    for (int k = 0; k < lat + 2; k++) step();
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [31:0] e;

    vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000};
    vecs[1] = '{32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF};
    vecs[2] = '{32'h0000_0020, 32'h1122_3344, 4'hF, 32'hDEAD_BEEF};
    vecs[3] = '{32'h0000_0020, 32'h0000_00AA, 4'h1, 32'hDEAD_BEEF};
    vecs[4] = '{32'h0000_0020, 32'h0000_0000, 4'h0, 32'h1122_33AA};
    vecs[5] = '{32'h0000_0004, 32'h0000_0055, 4'hF, 32'h1122_33AA};
    vecs[6] = '{32'h0000_4006, 32'h0000_0000, 4'h0, 32'h0000_0055};
    vecs[7] = '{32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF};

    checks = 0; failures = 0; cyc = 0;
    for (int i = 0; i < 4096; i++) mdl[i] = 32'h0;
    rst = 1'b1;
    bus0.req = 1'b0; bus0.addr = 32'h0; bus0.wdata = 32'h0; bus0.wstrb = 4'h0;
    bus1.req = 1'b0; bus1.addr = 32'h0; bus1.wdata = 32'h0; bus1.wstrb = 4'h0;

    // Reset: two cycles with req low, one more with req high (gnt must stay low).
    for (int k = 0; k < 3; k++) begin
      bus0.req = (k == 2);
      step();
      @(negedge clk);
      chk("rst_gnt", {31'd0, bus0.gnt}, 32'd0);
      chk("rst_dgnt", {31'd0, bus0.data_gnt}, 32'd0);
      chk("rst_rdata", bus0.rdata, 32'd0);
    end
    step();
    bus0.req = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      @(negedge clk);
      chk("idle_dgnt", {31'd0, bus0.data_gnt}, 32'd0);
      chk("idle_rdata", bus0.rdata, 32'd0);
    end
    step();

    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].exp_rd, $sformatf("vec%0d", i));
    end
    last_rd = 32'hDEAD_BEEF;

    b2b(0, LAT);
    b2b(1, 1);

    // Reset one cycle after a read grant: no completion, rdata cleared.
    bus0.req = 1'b1; bus0.addr = 32'h10; bus0.wstrb = 4'h0;
    @(negedge clk);
    chk("rstmid_gnt", {31'd0, bus0.gnt}, 32'd1);
    step();
    bus0.req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstmid_dgnt", {31'd0, bus0.data_gnt}, 32'd0);
      chk("rstmid_rdata", bus0.rdata, 32'd0);
      step();
    end
    last_rd = 32'h0;
    do_txn(32'h30, 32'h7, 4'hF, last_rd, "rstmid_wr");

    // Reset while a write is waiting: the write must already be in memory.
    bus0.req = 1'b1; bus0.addr = 32'h44; bus0.wdata = 32'hCAFE_F00D; bus0.wstrb = 4'hF;
    @(negedge clk);
    chk("rstwr_gnt", {31'd0, bus0.gnt}, 32'd1);
    step();
    bus0.req = 1'b0; bus0.wstrb = 4'h0;
    mdl_write(32'h44, 32'hCAFE_F00D, 4'hF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    do_txn(32'h44, 32'h0, 4'h0, 32'hCAFE_F00D, "rstwr_rd");
    last_rd = 32'hCAFE_F00D;
    do_txn(32'h30, 32'h0, 4'h0, 32'h0000_0007, "rstmid_rd30");
    last_rd = 32'h0000_0007;

    // Randomized traffic over 16 words with aliased upper bits and random byte offsets.
    for (int i = 0; i < 16; i++) begin
      a  = 32'(i * 4) | ($urandom & 32'hFFFF_C000);
      wd = $urandom;
      do_txn(a, wd, 4'hF, last_rd, "rnd_init");
    end
    for (int i = 0; i < 60; i++) begin
      a  = ($urandom & 32'hFFFF_C003) | 32'($urandom_range(0, 15) * 4);
      wd = $urandom;
      ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if (ws == 4'h0) begin
        e = mdl[widx(a)];
        last_rd = e;
      end else begin
        e = last_rd;
      end
      do_txn(a, wd, ws, e, "rnd");
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ladybird_ram_responder.md
Name: ladybird_ram_responder

Overview:
- Single-ported word RAM acting as the responder (secondary) end of the ladybird req/gnt/data_gnt memory bus.
- The core's instruction and data ports act as initiators on this bus; one instance of this block sits on each port in the simulation and FPGA top levels.
- Accepts one transaction at a time, performs a byte-strobed write or a word read, and returns a one-cycle data_gnt after a programmable latency.

Parameters:
- XLEN, 32, bus data/address width in bits.
- DEPTH_LOG2, 12, log2 of the number of XLEN-bit words stored.
- LATENCY, 2, cycles from grant to data_gnt; legal range 1..15.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset: synchronous, active-high.
- req  input  1  initiator request; addr and wstrb are valid while req=1.
- gnt  output  1  request accepted this cycle; combinational, gnt = req & (state==IDLE) & ~rst.
- addr  input  XLEN  byte address.
- wdata  input  XLEN  write data, sampled when gnt=1.
- wstrb  input  XLEN/8  byte-lane write enables; all zero means read.
- rdata  output  XLEN  read data register.
- data_gnt  output  1  one-cycle completion pulse, for both reads and writes.

Behaviour:
- Reset values: state=IDLE, latency counter=0, data_gnt=0, rdata=0. Memory array is not cleared.
- Word index = addr[DEPTH_LOG2+1:2].
  - addr[1:0] is ignored; unaligned accesses are treated as aligned.
  - Address bits above DEPTH_LOG2+1 are ignored, so the memory aliases modulo 4*2^DEPTH_LOG2 bytes.
- States:
  - IDLE: gnt follows req. On req=1, go to WAIT (LATENCY>1) or RESP (LATENCY=1), and load the counter with LATENCY-1.
  - WAIT: counter decrements each cycle. When counter==1, next state is RESP.
  - RESP: data_gnt=1 for exactly this cycle, then IDLE unconditionally.
- Grant-cycle actions (edge ending the gnt=1 cycle):
  - If wstrb!=0, write each byte lane i with wdata[8i+7:8i] where wstrb[i]=1. Other lanes keep their values.
  - If wstrb==0, rdata <= mem[index].
- rdata holds its value until the next granted read; writes never modify rdata.
- Latency: a request granted in cycle T has data_gnt=1 in cycle T+LATENCY.
- data_gnt is registered (high only in RESP state); no combinational path from req.
- Back-to-back: gnt=0 in WAIT and RESP, so the earliest next grant is cycle T+LATENCY+1.
- The initiator holds req/addr until gnt; req=1 with no gnt is simply stalled.
- A request withdrawn before gnt has no effect. req is not checked outside IDLE.
- Reset mid-transaction (rst=1 in WAIT or RESP):
  - Next cycle is IDLE with data_gnt=0; the pending response is dropped.
  - A write already performed at grant remains in memory.
  - rdata returns to 0.
- rst=1 forces gnt=0 in the same cycle, so no write occurs during reset.
- Read-after-write to the same word returns the new data, because there is only one outstanding transaction.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles, req=0 -> data_gnt=0, gnt=0, rdata=0 throughout and after release.
- Full-word write then read (LATENCY=2):
  - Write addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF -> gnt in T, data_gnt only in T+2.
  - Read addr=0x10 -> gnt in T', data_gnt in T'+2, rdata=0xDEADBEEF.
- Byte strobe: write 0x11223344 to 0x20 with wstrb=F, then 0x000000AA with wstrb=4'b0001, then read 0x20 -> rdata=0x112233AA.
- Aliasing and unaligned (DEPTH_LOG2=12): write 0x55 to 0x4, then read 0x4006 -> rdata=0x00000055 (index 1).
- Back-to-back with req held high for 3 reads:
  - Grants occur exactly every LATENCY+1 cycles.
  - No gnt while data_gnt=1.
  - LATENCY=1 gives gnt every 2 cycles.
- Reset mid-operation:
  - Assert rst one cycle after granting a read of 0x10 -> no data_gnt at T+2, rdata=0.
  - Then write 0x7 to 0x30 -> completes normally, data_gnt at +LATENCY.
